tc0200obj_rom_fetch: RTL and testbench

//  Sprite-ROM row fetcher directly downstream of the object code extender. Captures the extended 20-bit

---
 rtl/tc0200obj_pkg.sv | 32 +++
 rtl/tc0200obj_rom_fetch_if.sv | 30 +++
 rtl/tc0200obj_fetch_fifo.sv | 46 ++++
 rtl/tc0200obj_rom_fetch.sv | 158 +++++++++++++++
 tb/tb_tc0200obj_rom_fetch.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc0200obj_pkg.sv
// Shared types for the TC0200OBJ sprite-ROM row fetcher: request record, fetch FSM states and
// the horizontal-mirror helper for one 16-pixel 4bpp row.
package tc0200obj_pkg;

  localparam int PIX_BITS = 4;
  localparam int ROW_PIX  = 16;
  localparam int ROW_BITS = PIX_BITS * ROW_PIX;

  typedef struct packed {
    logic [19:0] code;
    logic [3:0]  row;
    logic        flip;
  } fetch_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    OUT  = 2'd3
  } fetch_state_e;

  // Pixel i of the result is pixel ROW_PIX-1-i of the input; bits inside a pixel keep their order.
  function automatic logic [ROW_BITS-1:0] flip_row(input logic [ROW_BITS-1:0] d);
    logic [ROW_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < ROW_PIX; i++) begin
      r[i*PIX_BITS +: PIX_BITS] = d[(ROW_PIX-1-i)*PIX_BITS +: PIX_BITS];
    end
    return r;
  endfunction

endpackage

// File: rtl/tc0200obj_rom_fetch_if.sv
// Signal bundle of the sprite-ROM row fetcher: request capture, ROM read port and renderer row port.
// Handshakes: rom_req/rom_addr are held until a one-cycle rom_ack (data valid with the ack);
// row_valid/row_data are held until a cycle with row_valid & row_ready, which transfers the row.
interface tc0200obj_rom_fetch_if #(
  parameter int ROM_AW = 25
);
  logic              code_req;
  logic [3:0]        row_idx;
  logic              flip_x;
  logic [19:0]       code_modified;
  logic              req_busy;
  logic              overflow;
  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ack;
  logic [31:0]       rom_data;
  logic              row_valid;
  logic              row_ready;
  logic [63:0]       row_data;

  modport master (
    output code_req, row_idx, flip_x, code_modified, rom_ack, rom_data, row_ready,
    input  req_busy, overflow, rom_req, rom_addr, row_valid, row_data
  );

  modport slave (
    input  code_req, row_idx, flip_x, code_modified, rom_ack, rom_data, row_ready,
    output req_busy, overflow, rom_req, rom_addr, row_valid, row_data
  );
endinterface

// File: rtl/tc0200obj_fetch_fifo.sv
// Synchronous FIFO of fetch requests; push and pop in the same cycle are allowed even when full.
module tc0200obj_fetch_fifo
  import tc0200obj_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_req_t               din_i,
  input  logic                     pop_i,
  output fetch_req_t               dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  fetch_req_t     mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    count_q;
  logic           full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/tc0200obj_rom_fetch.sv
// Sprite-ROM row fetcher: captures {code,row,flip}, reads two 32-bit words per row, emits 64-bit rows.
// Optional one-entry last-row cache enabled by defining TC0200OBJ_FETCH_CACHE_EN.
module tc0200obj_rom_fetch
  import tc0200obj_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int ROM_AW = 25
) (
  input  logic                      clk,
  input  logic                      reset_n,
  tc0200obj_rom_fetch_if.slave      bus,
  output fetch_state_e              dbg_state_o
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic              cap_valid_q, cap_flip_q, overflow_q;
  logic [3:0]        cap_row_q;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              req_busy, accept, fifo_empty, fifo_push, fifo_pop;
  logic              can_take, take, cache_hit;
  fetch_req_t        push_req, fifo_dout, head, cur_q;
  fetch_state_e      state_q;
  logic              rom_req_q, row_valid_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [31:0]       lo_q, hi_q;
  logic [63:0]       row_data_q, cache_row_data;

  function automatic logic [ROM_AW-1:0] mk_addr(input fetch_req_t r, input logic half);
    return ROM_AW'({r.code, r.row, half});
  endfunction

  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, cap_valid_q};
  assign req_busy  = (occupancy >= (CW+1)'(QDEPTH));
  assign accept    = bus.code_req & ~req_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid_q <= 1'b0;
      cap_row_q   <= '0;
      cap_flip_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cap_valid_q <= accept;
      if (accept) begin
        cap_row_q  <= bus.row_idx;
        cap_flip_q <= bus.flip_x;
      end
      if (bus.code_req && req_busy) overflow_q <= 1'b1;
    end
  end

  // A capture arriving while the FSM is free and the queue is empty bypasses the queue.
  assign push_req  = '{code: bus.code_modified, row: cap_row_q, flip: cap_flip_q};
  assign head      = fifo_empty ? push_req : fifo_dout;
  assign can_take  = (state_q == IDLE) || ((state_q == OUT) && row_valid_q && bus.row_ready);
  assign take      = can_take && (!fifo_empty || cap_valid_q);
  assign fifo_pop  = take && !fifo_empty;
  assign fifo_push = cap_valid_q && !(take && fifo_empty);

  tc0200obj_fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .din_i   (push_req),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef TC0200OBJ_FETCH_CACHE_EN
  logic        cache_valid_q;
  logic [19:0] cache_code_q;
  logic [3:0]  cache_idx_q;
  logic [63:0] cache_data_q;

  // Cached data is stored unflipped so either mirror setting can reuse it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid_q <= 1'b0;
      cache_code_q  <= '0;
      cache_idx_q   <= '0;
      cache_data_q  <= '0;
    end else if (state_q == HI && rom_req_q && bus.rom_ack) begin
      cache_valid_q <= 1'b1;
      cache_code_q  <= cur_q.code;
      cache_idx_q   <= cur_q.row;
      cache_data_q  <= {bus.rom_data, lo_q};
    end
  end

  assign cache_hit      = cache_valid_q && (head.code == cache_code_q) && (head.row == cache_idx_q);
  assign cache_row_data = cache_data_q;
`else
  assign cache_hit      = 1'b0;
  assign cache_row_data = '0;
`endif

  // rom_req falls for one cycle after every ack, so each ROM word is its own request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: ;
        LO: if (rom_req_q && bus.rom_ack) begin
          lo_q       <= bus.rom_data;
          rom_req_q  <= 1'b0;
          rom_addr_q <= mk_addr(cur_q, 1'b1);
          state_q    <= HI;
        end
        HI: if (!rom_req_q) begin
          rom_req_q <= 1'b1;
        end else if (bus.rom_ack) begin
          hi_q      <= bus.rom_data;
          rom_req_q <= 1'b0;
          state_q   <= OUT;
        end
        OUT: if (!row_valid_q) begin
          row_valid_q <= 1'b1;
          row_data_q  <= cur_q.flip ? flip_row({hi_q, lo_q}) : {hi_q, lo_q};
        end else if (bus.row_ready) begin
          row_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (take) begin
        cur_q <= head;
        if (cache_hit) begin
          state_q <= OUT;
          lo_q    <= cache_row_data[31:0];
          hi_q    <= cache_row_data[63:32];
        end else begin
          state_q    <= LO;
          rom_req_q  <= 1'b1;
          rom_addr_q <= mk_addr(head, 1'b0);
        end
      end
    end
  end

  assign bus.req_busy  = req_busy;
  assign bus.overflow  = overflow_q;
  assign bus.rom_req   = rom_req_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_data  = row_data_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_tc0200obj_rom_fetch.sv
// Directed bench for tc0200obj_rom_fetch; builds with or without TC0200OBJ_FETCH_CACHE_EN.
module tb_tc0200obj_rom_fetch;
  import tc0200obj_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  fetch_state_e dbg_state;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tc0200obj_rom_fetch_if #(.ROM_AW(25)) bus ();

  tc0200obj_rom_fetch #(.QDEPTH(4), .ROM_AW(25)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] addr_of(input logic [19:0] c, input logic [3:0] r, input logic h);
    return {c, r, h};
  endfunction

  function automatic logic [63:0] rev_nibbles(input logic [63:0] d);
    logic [63:0] s, r;
    s = d;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r = (r << 4) | {60'd0, s[3:0]};
      s = s >> 4;
    end
    return r;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    bus.code_req = 1'b0; bus.row_idx = '0; bus.flip_x = 1'b0; bus.code_modified = '0;
    bus.rom_ack = 1'b0; bus.rom_data = '0; bus.row_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic issue(input logic [19:0] code, input logic [3:0] row, input logic flip);
    bus.code_req = 1'b1; bus.row_idx = row; bus.flip_x = flip;
    step();
    bus.code_req = 1'b0; bus.code_modified = code;
    step();
  endtask

  task automatic serve(input logic [24:0] exp_addr, input logic [31:0] data, input int delay,
                       input string name);
    int n;
    n = 0;
    while (bus.rom_req !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (bus.rom_req !== 1'b1) begin
      failures++; $display("FAIL %s: rom_req got %b want 1 (timeout)", name, bus.rom_req);
    end else begin
      checks++;
      if (bus.rom_addr !== exp_addr) begin
        failures++; $display("FAIL %s: rom_addr got %h want %h", name, bus.rom_addr, exp_addr);
      end
      for (int i = 0; i < delay; i++) begin
        step();
        checks++;
        if (bus.rom_req !== 1'b1 || bus.rom_addr !== exp_addr) begin
          failures++;
          $display("FAIL %s_held: req/addr got %b/%h want 1/%h", name, bus.rom_req, bus.rom_addr, exp_addr);
        end
      end
      bus.rom_ack = 1'b1; bus.rom_data = data;
      step();
      bus.rom_ack = 1'b0; bus.rom_data = '0;
      checks++;
      if (bus.rom_req !== 1'b0) begin
        failures++; $display("FAIL %s_drop: rom_req got %b want 0", name, bus.rom_req);
      end
    end
  endtask

  task automatic wait_row(input logic [63:0] exp, input string name);
    int n;
    n = 0;
    while (bus.row_valid !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (bus.row_valid !== 1'b1) begin
      failures++; $display("FAIL %s: row_valid got %b want 1 (timeout)", name, bus.row_valid);
    end else begin
      checks++;
      if (bus.row_data !== exp) begin
        failures++; $display("FAIL %s: row_data got %h want %h", name, bus.row_data, exp);
      end
      bus.row_ready = 1'b1;
      step();
      bus.row_ready = 1'b0;
      checks++;
      if (bus.row_valid !== 1'b0) begin
        failures++; $display("FAIL %s_ack: row_valid got %b want 0", name, bus.row_valid);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (bus.rom_req !== 1'b0)   begin failures++; $display("FAIL reset_rom_req: got %b want 0", bus.rom_req); end
    if (bus.rom_addr !== '0)    begin failures++; $display("FAIL reset_rom_addr: got %h want 0", bus.rom_addr); end
    if (bus.row_valid !== 1'b0) begin failures++; $display("FAIL reset_row_valid: got %b want 0", bus.row_valid); end
    if (bus.row_data !== '0)    begin failures++; $display("FAIL reset_row_data: got %h want 0", bus.row_data); end
    if (bus.req_busy !== 1'b0)  begin failures++; $display("FAIL reset_req_busy: got %b want 0", bus.req_busy); end
    if (bus.overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    if (dbg_state !== IDLE)     begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_single();
    bus.code_req = 1'b1; bus.row_idx = 4'd3; bus.flip_x = 1'b0;
    step();
    bus.code_req = 1'b0; bus.code_modified = 20'h0ABCD;
    checks++;
    if (bus.rom_req !== 1'b0) begin failures++; $display("FAIL single_n1_req: got %b want 0", bus.rom_req); end
    step();
    checks++;
    if (bus.rom_req !== 1'b1) begin failures++; $display("FAIL single_n2_req: got %b want 1", bus.rom_req); end
    serve(addr_of(20'h0ABCD, 4'd3, 1'b0), 32'h11223344, 2, "single_lo");
    serve(addr_of(20'h0ABCD, 4'd3, 1'b1), 32'h55667788, 2, "single_hi");
    wait_row(64'h55667788_11223344, "single_row");
  endtask

  task automatic test_latency();
    bus.code_req = 1'b1; bus.row_idx = 4'd9; bus.flip_x = 1'b0;
    step();
    bus.code_req = 1'b0; bus.code_modified = 20'h00042;
    step();
    checks++;
    if (bus.rom_req !== 1'b1) begin failures++; $display("FAIL lat_n2_req: got %b want 1", bus.rom_req); end
    bus.rom_ack = 1'b1; bus.rom_data = 32'hCAFE0001;
    step();
    bus.rom_ack = 1'b0;
    checks++;
    if (bus.rom_req !== 1'b0) begin failures++; $display("FAIL lat_n3_req: got %b want 0", bus.rom_req); end
    step();
    checks++;
    if (bus.rom_req !== 1'b1 || bus.rom_addr !== addr_of(20'h00042, 4'd9, 1'b1)) begin
      failures++; $display("FAIL lat_n4_hi: req/addr got %b/%h", bus.rom_req, bus.rom_addr);
    end
    bus.rom_ack = 1'b1; bus.rom_data = 32'hBEEF0002;
    step();
    bus.rom_ack = 1'b0;
    checks++;
    if (bus.row_valid !== 1'b0) begin failures++; $display("FAIL lat_n5_valid: got %b want 0", bus.row_valid); end
    step();
    checks++;
    if (bus.row_valid !== 1'b1 || bus.row_data !== 64'hBEEF0002_CAFE0001) begin
      failures++; $display("FAIL lat_n6_row: valid/data got %b/%h want 1/beef0002cafe0001", bus.row_valid, bus.row_data);
    end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
  endtask

  task automatic test_flip();
    issue(20'h00001, 4'd0, 1'b1);
    serve(addr_of(20'h00001, 4'd0, 1'b0), 32'h76543210, 0, "flip_lo");
    serve(addr_of(20'h00001, 4'd0, 1'b1), 32'hFEDCBA98, 0, "flip_hi");
    wait_row(64'h01234567_89ABCDEF, "flip_row");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      bus.code_req = 1'b1; bus.row_idx = 4'(i); bus.flip_x = 1'b0;
      if (i > 0) bus.code_modified = 20'h10000 + 20'(i - 1);
      if (i == 5) begin
        checks++;
        if (bus.req_busy !== 1'b1) begin failures++; $display("FAIL ovf_busy: got %b want 1", bus.req_busy); end
      end
      step();
    end
    bus.code_req = 1'b0; bus.code_modified = 20'h10005;
    checks += 2;
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    if (bus.req_busy !== 1'b1) begin failures++; $display("FAIL ovf_full: got %b want 1", bus.req_busy); end
    for (int i = 0; i < 5; i++) begin
      serve(addr_of(20'h10000 + 20'(i), 4'(i), 1'b0), 32'hA0000000 + i, 0, "ovf_lo");
      serve(addr_of(20'h10000 + 20'(i), 4'(i), 1'b1), 32'hB0000000 + i, 0, "ovf_hi");
      wait_row({32'hB0000000 + i, 32'hA0000000 + i}, "ovf_row");
    end
    repeat (5) step();
    checks += 3;
    if (bus.rom_req !== 1'b0)  begin failures++; $display("FAIL ovf_dropped: rom_req got %b want 0", bus.rom_req); end
    if (bus.req_busy !== 1'b0) begin failures++; $display("FAIL ovf_drained: req_busy got %b want 0", bus.req_busy); end
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_kept: overflow got %b want 1", bus.overflow); end
  endtask

  task automatic test_hold();
    logic [63:0] exp;
    int n;
    exp = 64'h0000BBBB_AAAA0000;
    issue(20'h00AAA, 4'd2, 1'b0);
    serve(addr_of(20'h00AAA, 4'd2, 1'b0), 32'hAAAA0000, 0, "hold_lo");
    serve(addr_of(20'h00AAA, 4'd2, 1'b1), 32'h0000BBBB, 0, "hold_hi");
    n = 0;
    while (bus.row_valid !== 1'b1 && n < 20) begin step(); n++; end
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin bus.code_req = 1'b1; bus.row_idx = 4'd7; bus.flip_x = 1'b0; end
      if (c == 1) begin bus.code_req = 1'b0; bus.code_modified = 20'h00BBB; end
      step();
      checks++;
      if (bus.row_valid !== 1'b1 || bus.row_data !== exp || bus.rom_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_c%0d: valid/data/req got %b/%h/%b want 1/%h/0", c, bus.row_valid, bus.row_data, bus.rom_req, exp);
      end
    end
    wait_row(exp, "hold_release");
    serve(addr_of(20'h00BBB, 4'd7, 1'b0), 32'h00000001, 0, "hold_next_lo");
    serve(addr_of(20'h00BBB, 4'd7, 1'b1), 32'h00000002, 0, "hold_next_hi");
    wait_row(64'h00000002_00000001, "hold_next_row");
  endtask

  task automatic test_reset_midfetch();
    int bad;
    issue(20'h00777, 4'd1, 1'b0);
    issue(20'h00888, 4'd2, 1'b0);
    checks++;
    if (bus.rom_req !== 1'b1) begin failures++; $display("FAIL rst_pre_req: got %b want 1", bus.rom_req); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.rom_req !== 1'b0) begin failures++; $display("FAIL rst_async_req: got %b want 0", bus.rom_req); end
    bus.rom_ack = 1'b1; bus.rom_data = 32'hDEADBEEF;
    step();
    step();
    reset_n = 1'b1;
    step();
    bus.rom_ack = 1'b0; bus.rom_data = '0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.rom_req !== 1'b0 || bus.row_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_quiet: active cycles got %0d want 0", bad); end
    checks += 3;
    if (dbg_state !== IDLE)    begin failures++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    if (bus.req_busy !== 1'b0) begin failures++; $display("FAIL rst_flush: req_busy got %b want 0", bus.req_busy); end
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
  endtask

  task automatic test_same_code();
    issue(20'h00123, 4'd5, 1'b0);
    serve(addr_of(20'h00123, 4'd5, 1'b0), 32'h76543210, 0, "same_lo");
    serve(addr_of(20'h00123, 4'd5, 1'b1), 32'hFEDCBA98, 0, "same_hi");
    wait_row(64'hFEDCBA98_76543210, "same_row1");
    issue(20'h00123, 4'd5, 1'b1);
`ifdef TC0200OBJ_FETCH_CACHE_EN
    begin
      int n;
      logic saw_req;
      n = 0;
      saw_req = bus.rom_req;
      while (bus.row_valid !== 1'b1 && n < 20) begin
        step(); n++;
        if (bus.rom_req === 1'b1) saw_req = 1'b1;
      end
      checks++;
      if (saw_req !== 1'b0) begin failures++; $display("FAIL cache_no_rom: rom_req got %b want 0", saw_req); end
    end
`else
    serve(addr_of(20'h00123, 4'd5, 1'b0), 32'h76543210, 0, "same2_lo");
    serve(addr_of(20'h00123, 4'd5, 1'b1), 32'hFEDCBA98, 0, "same2_hi");
`endif
    wait_row(rev_nibbles(64'hFEDCBA98_76543210), "same_row2");
  endtask

  initial begin
    test_reset();
    test_single();
    test_latency();
    test_flip();
    test_overflow();
    test_hold();
    test_reset_midfetch();
    test_same_code();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
